// File: rtl/filter_feeder.sv
// filter_feeder: buffers host samples in a small FIFO and replays them to the
// 3-tap product filter as single-cycle smp_en strobes. Strobes are separated by
// at least GAP idle cycles so the filter's stop/go FSM can re-arm between samples.
// Optional feature: define FEEDER_DEDUP_EN to silently drop a queued sample equal
// to the last one strobed.
module filter_feeder #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 8,
    parameter  int GAP    = 1,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] host_data,
    input  logic              host_valid,
    output logic              host_ready,
    output logic [DATA_W-1:0] smp_data,
    output logic              smp_en,
    output logic [ADDR_W:0]   level,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] FULL_LEVEL = (ADDR_W + 1)'(DEPTH);
    localparam logic [7:0]      GAP_RELOAD = 8'(GAP - 1);

    // FIFO storage; read asynchronously so the head is visible in the issue cycle
    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] head_reg;
    logic [ADDR_W-1:0] tail_reg;
    logic [ADDR_W:0]   count_reg;
    logic [DATA_W-1:0] head_data;

    state_t            state_reg;
    state_t            state_next;
    logic [7:0]        gap_cnt_reg;
    logic [7:0]        gap_cnt_next;
    logic              smp_en_next;
    logic [DATA_W-1:0] smp_data_next;

    logic push;
    logic pop;
    logic issue_pt;
    logic dup;

    assign head_data  = mem[head_reg];
    assign host_ready = (count_reg != FULL_LEVEL);
    assign push       = host_valid & host_ready;
    assign level      = count_reg;
    assign busy       = (state_reg != IDLE) | (count_reg != '0);

`ifdef FEEDER_DEDUP_EN
    logic [DATA_W-1:0] last_sent_reg;
    logic              last_vld_reg;

    // A queued sample matching the previous strobe is dropped instead of sent
    assign dup = last_vld_reg && (head_data == last_sent_reg);

    // Remember the value of the most recent strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_sent_reg <= '0;
            last_vld_reg  <= 1'b0;
        end else if (smp_en_next) begin
            last_sent_reg <= smp_data_next;
            last_vld_reg  <= 1'b1;
        end
    end
`else
    assign dup = 1'b0;
`endif

    // Sample storage write at the tail; contents need no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_reg] <= host_data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves level unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (push) begin
                tail_reg <= tail_reg + 1'b1;
            end
            if (pop) begin
                head_reg <= head_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Strobe FSM next-state: issue, hold the strobe one cycle, then count out the gap
    always_comb begin
        state_next    = state_reg;
        gap_cnt_next  = gap_cnt_reg;
        smp_en_next   = 1'b0;
        smp_data_next = smp_data;
        pop           = 1'b0;
        issue_pt      = 1'b0;

        case (state_reg)
            IDLE: begin
                issue_pt = (count_reg != '0);
            end
            SEND: begin
                state_next   = WAIT;
                gap_cnt_next = GAP_RELOAD;
            end
            WAIT: begin
                if (gap_cnt_reg != 8'd0) begin
                    gap_cnt_next = gap_cnt_reg - 8'd1;
                end else if (count_reg != '0) begin
                    issue_pt = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A duplicate is popped silently and the FSM stays at the issue point
        if (issue_pt) begin
            pop = 1'b1;
            if (!dup) begin
                smp_en_next   = 1'b1;
                smp_data_next = head_data;
                state_next    = SEND;
            end
        end
    end

    // FSM state and registered strobe outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            gap_cnt_reg <= 8'd0;
            smp_en      <= 1'b0;
            smp_data    <= '0;
        end else begin
            state_reg   <= state_next;
            gap_cnt_reg <= gap_cnt_next;
            smp_en      <= smp_en_next;
            smp_data    <= smp_data_next;
        end
    end

endmodule

// File: tb/tb_filter_feeder.sv
// tb_filter_feeder: directed stimulus with a queue-based reference model of the
// feeder, compared on every falling edge, plus hand-computed literal checks.
module tb_filter_feeder;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int GAP   = 2;
`ifdef FEEDER_DEDUP_EN
    localparam bit DEDUP = 1'b1;
`else
    localparam bit DEDUP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] host_data;
    logic          host_valid;
    logic          host_ready;
    logic [DW-1:0] smp_data;
    logic          smp_en;
    logic [3:0]    level;
    logic          busy;

    int tests = 0;
    int fails = 0;
    int tb_cyc = 0;

    filter_feeder #(.DATA_W(DW), .DEPTH(DEPTH), .GAP(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .host_data  (host_data),
        .host_valid (host_valid),
        .host_ready (host_ready),
        .smp_data   (smp_data),
        .smp_en     (smp_en),
        .level      (level),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tb_cyc++;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // ---------------- reference model ----------------
    // Rule: a sample leaves the queue at the end of any cycle in which the queue is
    // non-empty and at least GAP cycles have passed since the last strobe cycle.
    logic [DW-1:0] mq[$];
    int            m_cyc;
    int            m_slast;
    bit            m_idle;
    bit            m_en;
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_last;
    bit            m_last_vld;
    bit            m_strobe;
    bit            m_take;
    bit            m_push;
    bit            m_gap_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_cyc      = 0;
            m_slast    = -1000;
            m_idle     = 1'b1;
            m_en       = 1'b0;
            m_data     = '0;
            m_last     = '0;
            m_last_vld = 1'b0;
        end else begin
            m_gap_done = (m_cyc >= m_slast + GAP);
            m_strobe   = 1'b0;
            m_take     = 1'b0;
            if (mq.size() != 0 && m_gap_done) begin
                m_take = 1'b1;
                if (!(DEDUP && m_last_vld && mq[0] == m_last)) begin
                    m_strobe   = 1'b1;
                    m_data     = mq[0];
                    m_last     = mq[0];
                    m_last_vld = 1'b1;
                end
            end
            m_push = host_valid && (mq.size() != DEPTH);
            if (m_strobe)
                m_idle = 1'b0;
            else if (m_gap_done && mq.size() == 0)
                m_idle = 1'b1;
            if (m_take) void'(mq.pop_front());
            if (m_push) mq.push_back(host_data);
            m_cyc++;
            if (m_strobe) m_slast = m_cyc;
            m_en = m_strobe;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        check("cyc_smp_en",     smp_en,     m_en);
        check("cyc_smp_data",   smp_data,   m_data);
        check("cyc_level",      level,      mq.size());
        check("cyc_host_ready", host_ready, mq.size() != DEPTH);
        check("cyc_busy",       busy,       (!m_idle) || (mq.size() != 0));
    end

    // Strobe log: one line per delivered sample
    logic [DW-1:0] log_q[$];
    int            logc_q[$];

    always @(negedge clk) begin
        if (smp_en === 1'b1) begin
            log_q.push_back(smp_data);
            logc_q.push_back(tb_cyc);
            $display("[TB] strobe data=%02h cycle=%0d level=%0d", smp_data, tb_cyc, level);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [DW-1:0] stim[$];

    task automatic apply_reset();
        @(posedge clk);
        #2 rst = 1'b1;
        host_valid = 1'b0;
        log_q.delete();
        logc_q.delete();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drive_stim();
        @(negedge clk);
        foreach (stim[i]) begin
            host_valid = 1'b1;
            host_data  = stim[i];
            @(negedge clk);
        end
        host_valid = 1'b0;
        stim.delete();
    endtask

    task automatic wait_drain(string name);
        int n = 0;
        while (busy !== 1'b0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, n < 300, 1);
    endtask

    int prod;

    initial begin
        rst        = 1'b1;
        host_valid = 1'b0;
        host_data  = '0;
        repeat (2) @(negedge clk);

        // T1: reset state and single-sample latency
        check("rst_smp_en",     smp_en,     0);
        check("rst_smp_data",   smp_data,   0);
        check("rst_level",      level,      0);
        check("rst_host_ready", host_ready, 1);
        check("rst_busy",       busy,       0);
        rst = 1'b0;
        @(negedge clk);
        host_valid = 1'b1;
        host_data  = 8'h05;
        @(negedge clk);
        host_valid = 1'b0;
        check("t1_level_after_push", level, 1);
        check("t1_no_early_strobe", smp_en, 0);
        @(negedge clk);
        check("t1_strobe",     smp_en,   1);
        check("t1_data",       smp_data, 8'h05);
        check("t1_level_zero", level,    0);
        @(negedge clk);
        check("t1_strobe_off", smp_en, 0);
        check("t1_busy_gap",   busy,   1);
        repeat (2) @(negedge clk);
        check("t1_busy_done",  busy,     0);
        check("t1_data_held",  smp_data, 8'h05);

        // T2: back-to-back pushes give strictly spaced strobes in order
        apply_reset();
        stim.push_back(8'h01);
        stim.push_back(8'h02);
        stim.push_back(8'h03);
        drive_stim();
        wait_drain("t2_drain");
        check("t2_count", log_q.size(), 3);
        if (log_q.size() == 3) begin
            check("t2_d0", log_q[0], 8'h01);
            check("t2_d1", log_q[1], 8'h02);
            check("t2_d2", log_q[2], 8'h03);
            check("t2_gap01", logc_q[1] - logc_q[0], GAP + 1);
            check("t2_gap12", logc_q[2] - logc_q[1], GAP + 1);
        end

        // T3: continuous push overtakes the slow drain and fills the FIFO
        apply_reset();
        @(negedge clk);
        host_valid = 1'b1;
        host_data  = 8'h10;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            host_data = 8'(8'h10 + i);
        end
        check("t3_level_full", level,      8);
        check("t3_not_ready",  host_ready, 0);
        repeat (6) @(negedge clk);
        host_valid = 1'b0;
        wait_drain("t3_drain");
        if (log_q.size() != 0) check("t3_first", log_q[0], 8'h10);

        // T4: asynchronous reset while level=5 and a strobe is in progress
        apply_reset();
        @(negedge clk);
        host_valid = 1'b1;
        host_data  = 8'h20;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            host_data = 8'(8'h20 + i);
        end
        check("t4_pre_level", level,  5);
        check("t4_pre_en",    smp_en, 1);
        #2 rst = 1'b1;
        host_valid = 1'b0;
        #1;
        check("t4_rst_en",    smp_en,     0);
        check("t4_rst_level", level,      0);
        check("t4_rst_ready", host_ready, 1);
        check("t4_rst_busy",  busy,       0);
        log_q.delete();
        logc_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("t4_no_strobes", log_q.size(), 0);

        // T5: repeated values (dropped only when deduplication is built in)
        apply_reset();
        stim.push_back(8'h07);
        stim.push_back(8'h07);
        stim.push_back(8'h07);
        stim.push_back(8'h09);
        drive_stim();
        wait_drain("t5_drain");
        check("t5_count", log_q.size(), DEDUP ? 2 : 4);
        if (log_q.size() >= 2) begin
            check("t5_first", log_q[0], 8'h07);
            check("t5_last",  log_q[log_q.size() - 1], 8'h09);
            for (int i = 1; i < log_q.size(); i++)
                check("t5_spacing", (logc_q[i] - logc_q[i-1]) >= GAP + 1, 1);
        end

        // T6: samples for the product filter, 2*3*4
        apply_reset();
        stim.push_back(8'h02);
        stim.push_back(8'h03);
        stim.push_back(8'h04);
        drive_stim();
        wait_drain("t6_drain");
        prod = 1;
        foreach (log_q[i]) prod = prod * int'(log_q[i]);
        check("t6_count",   log_q.size(), 3);
        check("t6_product", prod, 24);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
